// File: rtl/processor_control_unit_if.sv
// Control bundle between the instruction sequencer and the register/bus datapath.
// The master is the sequencer, which initiates every bus transfer; the slave is the datapath or a bench.
interface processor_control_unit_if;
    logic       Run;
    logic [7:0] DIN;
    logic [4:0] S;
    logic [3:0] Rin;
    logic       IRin;
    logic       Ain;
    logic       Gin;
    logic       AddSub;
    logic       Gout;
    logic       Done;
    logic       Busy;
    // Sequencer step (0..3 = T0..T3) and instruction register, exported for observation
    logic [1:0] state_dbg;
    logic [7:0] ir_dbg;

    modport master (
        input  Run, DIN,
        output S, Rin, IRin, Ain, Gin, AddSub, Gout, Done, Busy, state_dbg, ir_dbg
    );

    modport slave (
        output Run, DIN,
        input  S, Rin, IRin, Ain, Gin, AddSub, Gout, Done, Busy, state_dbg, ir_dbg
    );
endinterface

// File: rtl/processor_control_unit.sv
// Instruction sequencer for the 8-bit, four-register bus datapath.
// It decodes mv/mvi/add/sub and steps the bus selects and load strobes through T0..T3.
module processor_control_unit (
    input  logic                           Clk,
    input  logic                           Reset,
    processor_control_unit_if.master       bus
);
    typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} state_t;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    state_t     state;
    logic [7:0] ir;
    logic [2:0] opcode;
    logic [1:0] rx;
    logic [1:0] ry;
    logic       is_alu;

    assign opcode = ir[7:5];
    assign rx     = ir[3:2];
    assign ry     = ir[1:0];
    assign is_alu = (opcode == OP_ADD) || (opcode == OP_SUB);

    function automatic logic [4:0] reg_sel(input logic [1:0] idx);
        return 5'b00001 << idx;
    endfunction

    function automatic logic [3:0] reg_load(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= T0;
            ir    <= 8'h00;
        end else begin
            case (state)
                T0: begin
                    if (bus.Run) begin
                        ir    <= bus.DIN;
                        state <= T1;
                    end
                end
                T1:      state <= is_alu ? T2 : T0;
                T2:      state <= T3;
                T3:      state <= T0;
                default: state <= T0;
            endcase
        end
    end

    // Strobes are decoded from the current step and IR; Reset masks them in the same cycle.
    always_comb begin
        bus.S      = 5'b00000;
        bus.Rin    = 4'b0000;
        bus.IRin   = 1'b0;
        bus.Ain    = 1'b0;
        bus.Gin    = 1'b0;
        bus.AddSub = 1'b0;
        bus.Gout   = 1'b0;
        bus.Done   = 1'b0;
        bus.Busy   = 1'b0;
        if (!Reset) begin
            bus.Busy = (state != T0);
            case (state)
                T0: bus.IRin = bus.Run;
                T1: begin
                    case (opcode)
                        OP_MV: begin
                            bus.S    = reg_sel(ry);
                            bus.Rin  = reg_load(rx);
                            bus.Done = 1'b1;
                        end
                        OP_MVI: begin
                            bus.S    = 5'b10000;
                            bus.Rin  = reg_load(rx);
                            bus.Done = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            bus.S   = reg_sel(rx);
                            bus.Ain = 1'b1;
                        end
                        default: bus.Done = 1'b1;
                    endcase
                end
                T2: begin
                    bus.S      = reg_sel(ry);
                    bus.Gin    = 1'b1;
                    bus.AddSub = (opcode == OP_SUB);
                end
                T3: begin
                    bus.Gout = 1'b1;
                    bus.Rin  = reg_load(rx);
                    bus.Done = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.state_dbg = state;
    assign bus.ir_dbg    = ir;
endmodule

// File: tb/tb_processor_control_unit.sv
// Directed bench for processor_control_unit: each driven cycle pushes its expected strobe
// vector into a queue, and a monitor on the falling edge pops and compares.
module tb_processor_control_unit;
    localparam int W = 26;

    logic Clk;
    logic Reset;

    processor_control_unit_if bus ();

    processor_control_unit dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.master)
    );

    // clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           tests_run = 0;
    int           tests_failed = 0;

    localparam logic [1:0] T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3;

    // {S, Rin, IRin, Ain, Gin, AddSub, Gout, Done, Busy, state, IR}
    function automatic logic [W-1:0] mk(input logic [4:0] s, input logic [3:0] rin,
                                        input logic irin, input logic ain, input logic gin,
                                        input logic addsub, input logic gout, input logic done,
                                        input logic busy, input logic [1:0] st, input logic [7:0] ir);
        return {s, rin, irin, ain, gin, addsub, gout, done, busy, st, ir};
    endfunction

    logic [W-1:0] act;
    assign act = {bus.S, bus.Rin, bus.IRin, bus.Ain, bus.Gin, bus.AddSub, bus.Gout,
                  bus.Done, bus.Busy, bus.state_dbg, bus.ir_dbg};

    // scoreboard monitor
    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            string        n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            tests_run++;
            if (act !== e) begin
                tests_failed++;
                $display("FAIL %s: got S=%b Rin=%b IRin=%b Ain=%b Gin=%b AddSub=%b Gout=%b Done=%b Busy=%b st=%0d IR=%h, want S=%b Rin=%b IRin=%b Ain=%b Gin=%b AddSub=%b Gout=%b Done=%b Busy=%b st=%0d IR=%h",
                         n, act[25:21], act[20:17], act[16], act[15], act[14], act[13], act[12], act[11], act[10], act[9:8], act[7:0],
                         e[25:21], e[20:17], e[16], e[15], e[14], e[13], e[12], e[11], e[10], e[9:8], e[7:0]);
            end
        end
    end

    // driver: apply inputs just after a rising edge, record the expected response for this cycle
    task automatic cyc(input logic rst, input logic run, input logic [7:0] din,
                       input logic [W-1:0] exp, input string nm);
        Reset   = rst;
        bus.Run = run;
        bus.DIN = din;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got still running, want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset   = 1'b1;
        bus.Run = 1'b1;
        bus.DIN = 8'h2D;
        @(posedge Clk);
        #1;

        // reset held with Run high: all strobes masked
        cyc(1, 1, 8'h2D, mk(5'b00000, 4'b0000, 0,0,0,0,0,0,0, T0, 8'h00), "reset_c0");
        cyc(1, 1, 8'h2D, mk(5'b00000, 4'b0000, 0,0,0,0,0,0,0, T0, 8'h00), "reset_c1");

        // mvi R1,#0x5A
        cyc(0, 1, 8'h24, mk(5'b00000, 4'b0000, 1,0,0,0,0,0,0, T0, 8'h00), "mvi_t0");
        cyc(0, 0, 8'h5A, mk(5'b10000, 4'b0010, 0,0,0,0,0,1,1, T1, 8'h24), "mvi_t1");
        cyc(0, 0, 8'h00, mk(5'b00000, 4'b0000, 0,0,0,0,0,0,0, T0, 8'h24), "idle_after_mvi");

        // mv R3,R0
        cyc(0, 1, 8'h0C, mk(5'b00000, 4'b0000, 1,0,0,0,0,0,0, T0, 8'h24), "mv_t0");
        cyc(0, 1, 8'hFF, mk(5'b00001, 4'b1000, 0,0,0,0,0,1,1, T1, 8'h0C), "mv_t1");

        // sub R2,R1 captured back-to-back, Run held high
        cyc(0, 1, 8'h69, mk(5'b00000, 4'b0000, 1,0,0,0,0,0,0, T0, 8'h0C), "sub_t0");
        cyc(0, 1, 8'h00, mk(5'b00100, 4'b0000, 0,1,0,0,0,0,1, T1, 8'h69), "sub_t1");
        cyc(0, 1, 8'h00, mk(5'b00010, 4'b0000, 0,0,1,1,0,0,1, T2, 8'h69), "sub_t2");
        cyc(0, 1, 8'h00, mk(5'b00000, 4'b0100, 0,0,0,0,1,1,1, T3, 8'h69), "sub_t3");

        // add R0,R3 aborted by reset in T2
        cyc(0, 1, 8'h43, mk(5'b00000, 4'b0000, 1,0,0,0,0,0,0, T0, 8'h69), "add_t0");
        cyc(0, 0, 8'h00, mk(5'b00001, 4'b0000, 0,1,0,0,0,0,1, T1, 8'h43), "add_t1");
        cyc(1, 0, 8'h00, mk(5'b00000, 4'b0000, 0,0,0,0,0,0,0, T2, 8'h43), "add_t2_reset");
        cyc(0, 0, 8'h00, mk(5'b00000, 4'b0000, 0,0,0,0,0,0,0, T0, 8'h00), "after_abort");

        // reserved opcode as nop, then mv R0,R0 with Run still high
        cyc(0, 1, 8'hE5, mk(5'b00000, 4'b0000, 1,0,0,0,0,0,0, T0, 8'h00), "nop_t0");
        cyc(0, 1, 8'h00, mk(5'b00000, 4'b0000, 0,0,0,0,0,1,1, T1, 8'hE5), "nop_t1");
        cyc(0, 1, 8'h00, mk(5'b00000, 4'b0000, 1,0,0,0,0,0,0, T0, 8'hE5), "mv00_t0");
        cyc(0, 0, 8'h00, mk(5'b00001, 4'b0001, 0,0,0,0,0,1,1, T1, 8'h00), "mv00_t1");
        cyc(0, 0, 8'h33, mk(5'b00000, 4'b0000, 0,0,0,0,0,0,0, T0, 8'h00), "idle_run_low");

        // add R1,R1: X==Y, AddSub low for add
        cyc(0, 1, 8'h45, mk(5'b00000, 4'b0000, 1,0,0,0,0,0,0, T0, 8'h00), "addxx_t0");
        cyc(0, 0, 8'h00, mk(5'b00010, 4'b0000, 0,1,0,0,0,0,1, T1, 8'h45), "addxx_t1");
        cyc(0, 0, 8'h00, mk(5'b00010, 4'b0000, 0,0,1,0,0,0,1, T2, 8'h45), "addxx_t2");
        cyc(0, 0, 8'h00, mk(5'b00000, 4'b0010, 0,0,0,0,1,1,1, T3, 8'h45), "addxx_t3");

        // mvi R3 with a different immediate, Run ignored in T1
        cyc(0, 1, 8'h2C, mk(5'b00000, 4'b0000, 1,0,0,0,0,0,0, T0, 8'h45), "mvi3_t0");
        cyc(0, 1, 8'hA5, mk(5'b10000, 4'b1000, 0,0,0,0,0,1,1, T1, 8'h2C), "mvi3_t1");
        cyc(0, 0, 8'h00, mk(5'b00000, 4'b0000, 0,0,0,0,0,0,0, T0, 8'h2C), "final_idle");

        if (exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
